// File: rtl/port_ctrl_arbiter.sv
// port_ctrl_arbiter: shares the TRIS/PORT write path of one I/O port between
// the CPU (always wins) and NREQ peripherals. Peripherals take turns through a
// round-robin req/gnt handshake with a bounded hold time and masked writes.
module port_ctrl_arbiter #(
  parameter int              WIDTH      = 8,
  parameter int              NREQ       = 2,
  parameter int              HOLD_MAX   = 16,
  parameter logic [WIDTH-1:0] RESET_TRIS = '1,
  parameter logic [WIDTH-1:0] RESET_PORT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      cpu_tris_in,
  input  logic                  cpu_tris_wr_en,
  input  logic [WIDTH-1:0]      cpu_port_in,
  input  logic                  cpu_port_wr_en,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  input  logic [NREQ*WIDTH-1:0] per_mask,
  input  logic [NREQ*WIDTH-1:0] per_tris_in,
  input  logic [NREQ*WIDTH-1:0] per_port_in,
  input  logic [NREQ-1:0]       per_tris_wr_en,
  input  logic [NREQ-1:0]       per_port_wr_en,
  output logic [WIDTH-1:0]      tris_in,
  output logic [WIDTH-1:0]      port_in,
  output logic                  tris_wr_en,
  output logic                  port_wr_en,
  output logic                  conflict,
  output logic                  timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD_MAX);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]       state_reg;
  logic [IW-1:0]    owner_reg;
  logic [IW-1:0]    rr_ptr_reg;
  logic [CW-1:0]    hold_cnt_reg;
  logic [WIDTH-1:0] tris_sh_reg;
  logic [WIDTH-1:0] port_sh_reg;
  logic             tris_wr_en_reg;
  logic             port_wr_en_reg;
  logic             conflict_reg;
  logic             timeout_reg;

  logic [NREQ-1:0]  req_rot;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    owner_succ;
  logic             owner_req;
  logic             owner_at_limit;
  logic             own_tris_wr;
  logic             own_port_wr;
  logic [WIDTH-1:0] own_mask;
  logic [WIDTH-1:0] own_tris_data;
  logic [WIDTH-1:0] own_port_data;
  logic [WIDTH-1:0] tris_next;
  logic [WIDTH-1:0] port_next;

  // Grant is decoded from the registered owner so it changes only on edges.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = (state_reg == OWN) && (owner_reg == IW'(gi));
    end
  endgenerate

  // Rotate requests so bit k is requester (rr_ptr + k) mod NREQ.
  assign req_rot = NREQ'({req, req} >> rr_ptr_reg);

  // Pick the first rotated request; scanning downward lets the lowest offset win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(rr_ptr_reg) + k) % NREQ);
      end
    end
  end

  assign owner_succ     = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + IW'(1);
  assign owner_req      = |(req & gnt);
  assign owner_at_limit = (hold_cnt_reg == CW'(HOLD_MAX - 1));
  assign own_tris_wr    = |(per_tris_wr_en & gnt);
  assign own_port_wr    = |(per_port_wr_en & gnt);

  // Select the current owner's mask and data (gnt is one-hot or zero).
  always_comb begin
    own_mask      = '0;
    own_tris_data = '0;
    own_port_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        own_mask      = own_mask      | per_mask[i*WIDTH +: WIDTH];
        own_tris_data = own_tris_data | per_tris_in[i*WIDTH +: WIDTH];
        own_port_data = own_port_data | per_port_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // CPU writes replace the full register; owner writes only touch masked bits.
  always_comb begin
    tris_next = cpu_tris_wr_en ? cpu_tris_in
                               : (tris_sh_reg & ~own_mask) | (own_tris_data & own_mask);
    port_next = cpu_port_wr_en ? cpu_port_in
                               : (port_sh_reg & ~own_mask) | (own_port_data & own_mask);
  end

  // Ownership FSM: round-robin grant, release on req drop or hold timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg    <= OWN;
            owner_reg    <= pick_idx;
            hold_cnt_reg <= '0;
          end
        end
        OWN: begin
          hold_cnt_reg <= hold_cnt_reg + CW'(1);
          if (!owner_req || owner_at_limit) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= owner_succ;
            hold_cnt_reg <= '0;
            timeout_reg  <= owner_req;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write path: shadows track the last issued value; strobes last one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tris_sh_reg    <= RESET_TRIS;
      port_sh_reg    <= RESET_PORT;
      tris_wr_en_reg <= 1'b0;
      port_wr_en_reg <= 1'b0;
      conflict_reg   <= 1'b0;
    end else begin
      tris_wr_en_reg <= cpu_tris_wr_en | own_tris_wr;
      port_wr_en_reg <= cpu_port_wr_en | own_port_wr;
      conflict_reg   <= (cpu_tris_wr_en & own_tris_wr) | (cpu_port_wr_en & own_port_wr);
      if (cpu_tris_wr_en || own_tris_wr) tris_sh_reg <= tris_next;
      if (cpu_port_wr_en || own_port_wr) port_sh_reg <= port_next;
    end
  end

  assign tris_in    = tris_sh_reg;
  assign port_in    = port_sh_reg;
  assign tris_wr_en = tris_wr_en_reg;
  assign port_wr_en = port_wr_en_reg;
  assign conflict   = conflict_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_port_ctrl_arbiter.sv
// Testbench for port_ctrl_arbiter: directed test-plan scenarios plus random
// traffic, checked against a behavioural model through a per-cycle scoreboard.
module tb_port_ctrl_arbiter;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int HM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   cpu_tris_in, cpu_port_in;
  logic           cpu_tris_wr_en, cpu_port_wr_en;
  logic [N-1:0]   req, gnt;
  logic [N*W-1:0] per_mask, per_tris_in, per_port_in;
  logic [N-1:0]   per_tris_wr_en, per_port_wr_en;
  logic [W-1:0]   tris_in, port_in;
  logic           tris_wr_en, port_wr_en, conflict, timeout;

  always #5 clk = ~clk;

  port_ctrl_arbiter #(
    .WIDTH(W), .NREQ(N), .HOLD_MAX(HM), .RESET_TRIS(8'hFF), .RESET_PORT(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_tris_in(cpu_tris_in), .cpu_tris_wr_en(cpu_tris_wr_en),
    .cpu_port_in(cpu_port_in), .cpu_port_wr_en(cpu_port_wr_en),
    .req(req), .gnt(gnt), .per_mask(per_mask),
    .per_tris_in(per_tris_in), .per_port_in(per_port_in),
    .per_tris_wr_en(per_tris_wr_en), .per_port_wr_en(per_port_wr_en),
    .tris_in(tris_in), .port_in(port_in),
    .tris_wr_en(tris_wr_en), .port_wr_en(port_wr_en),
    .conflict(conflict), .timeout(timeout)
  );

  typedef struct {
    int          cyc;
    logic [21:0] vec;  // {gnt, tris_wr_en, port_wr_en, tris_in, port_in, conflict, timeout}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   running  = 1'b1;

  // Reference model: owner as an integer (-1 = nobody), cycles held so far.
  int         m_own  = -1;
  int         m_rr   = 0;
  int         m_held = 0;
  logic [7:0] m_tris = 8'hFF;
  logic [7:0] m_port = 8'h00;

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] v, input int i);
    logic [N*W-1:0] s;
    s = v >> (i * W);
    return s[W-1:0];
  endfunction

  task automatic model_step();
    logic [1:0] g;
    logic twe, pwe, cf, to, otw, opw;
    logic [7:0] mk;
    int cur, i;
    twe = 0; pwe = 0; cf = 0; to = 0;
    if (!rst_n) begin
      m_own = -1; m_rr = 0; m_held = 0; m_tris = 8'hFF; m_port = 8'h00;
    end else begin
      cur = m_own;
      otw = (cur >= 0) && bit_of(per_tris_wr_en, cur);
      opw = (cur >= 0) && bit_of(per_port_wr_en, cur);
      mk  = (cur >= 0) ? slice_of(per_mask, cur) : 8'h00;
      if (cpu_tris_wr_en) begin
        m_tris = cpu_tris_in; twe = 1; if (otw) cf = 1;
      end else if (otw) begin
        m_tris = (m_tris & ~mk) | (slice_of(per_tris_in, cur) & mk); twe = 1;
      end
      if (cpu_port_wr_en) begin
        m_port = cpu_port_in; pwe = 1; if (opw) cf = 1;
      end else if (opw) begin
        m_port = (m_port & ~mk) | (slice_of(per_port_in, cur) & mk); pwe = 1;
      end
      if (m_own < 0) begin
        for (int k = 0; k < N; k++) begin
          i = (m_rr + k) % N;
          if (bit_of(req, i)) begin
            m_own = i; m_held = 0; break;
          end
        end
      end else begin
        m_held++;
        if (!bit_of(req, m_own)) begin
          m_rr = (m_own + 1) % N; m_own = -1;
        end else if (m_held == HM) begin
          to = 1; m_rr = (m_own + 1) % N; m_own = -1;
        end
      end
    end
    g = (m_own >= 0) ? 2'(1 << m_own) : 2'b00;
    exp_q.push_back('{cyc + 1, {g, twe, pwe, m_tris, m_port, cf, to}});
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    cpu_tris_wr_en = 0; cpu_port_wr_en = 0;
    per_tris_wr_en = '0; per_port_wr_en = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req_v);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per observed output cycle.
  always @(posedge clk) begin
    exp_t e;
    logic [21:0] act;
    #1;
    act = {gnt, tris_wr_en, port_wr_en, tris_in, port_in, conflict, timeout};
    if (running) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard cyc %0d: got %h, required a queued entry", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act === e.vec) n_pass++;
        else $display("FAIL cycle %0d outputs: got %h, required %h", e.cyc, act, e.vec);
      end
      if (tris_wr_en || port_wr_en || conflict || timeout)
        $display("txn cyc %0d gnt=%b twe=%b pwe=%b tris=%h port=%h cf=%b to=%b",
                 cyc, gnt, tris_wr_en, port_wr_en, tris_in, port_in, conflict, timeout);
    end
  end

  logic [1:0] to_gnt [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};

  initial begin
    // Reset with strobes active.
    rst_n = 0; req = 2'b11; per_mask = '1;
    cpu_tris_in = 8'h00; cpu_tris_wr_en = 1; cpu_port_in = 8'h5A; cpu_port_wr_en = 1;
    per_tris_in = '0; per_port_in = '1; per_tris_wr_en = 2'b11; per_port_wr_en = 2'b11;
    tick(); tick();
    chk("reset gnt", gnt, 0);
    chk("reset wr_en", {tris_wr_en, port_wr_en, conflict, timeout}, 0);
    chk("reset tris_in", tris_in, 8'hFF);
    chk("reset port_in", port_in, 8'h00);

    // Masked owner write, with a non-owner strobing at the same time.
    rst_n = 1; clr(); req = 2'b00;
    cpu_port_wr_en = 1; cpu_port_in = 8'hA0; tick(); clr();
    chk("cpu port write", {port_wr_en, port_in}, 9'h1A0);
    req = 2'b01; tick();
    chk("grant 0", gnt, 2'b01);
    per_mask = {8'hFF, 8'h0F}; per_port_in = {8'h33, 8'hFF}; per_port_wr_en = 2'b11;
    tick(); clr();
    chk("masked write", {port_wr_en, port_in}, 9'h1AF);

    // Collision on PORT, then CPU TRIS alongside owner PORT.
    per_port_in = {8'h33, 8'h0F}; per_port_wr_en = 2'b01;
    cpu_port_wr_en = 1; cpu_port_in = 8'h55; tick(); clr();
    chk("collision port", {port_wr_en, port_in}, 9'h155);
    chk("collision conflict", conflict, 1);
    cpu_tris_wr_en = 1; cpu_tris_in = 8'h3C; per_port_wr_en = 2'b01; tick(); clr();
    chk("split tris", {tris_wr_en, tris_in}, 9'h13C);
    chk("split port", {port_wr_en, port_in}, 9'h15F);
    chk("split no conflict", conflict, 0);
    req = 2'b00; tick();
    chk("release", {gnt, timeout}, 0);

    // Round-robin from reset.
    rst_n = 0; tick(); rst_n = 1;
    req = 2'b11; tick(); chk("rr first", gnt, 2'b01);
    tick();
    req = 2'b10; tick(); chk("rr idle gap", gnt, 2'b00);
    tick(); chk("rr second", gnt, 2'b10);
    req = 2'b01; tick(); chk("rr release 1", gnt, 2'b00);
    req = 2'b11; tick(); chk("rr back to 0", gnt, 2'b01);
    req = 2'b00; tick(); tick();

    // Timeout with a sole requester; owner write in the forced-release cycle.
    req = 2'b01; per_tris_in = {8'h00, 8'hC3};
    for (int t = 1; t <= 6; t++) begin
      if (t == 5) per_tris_wr_en = 2'b01;
      tick(); clr();
      chk($sformatf("timeout gnt t%0d", t), gnt, to_gnt[t-1]);
      chk($sformatf("timeout pulse t%0d", t), timeout, (t == 5) ? 1 : 0);
      if (t == 5) chk("release-cycle write", {tris_wr_en, tris_in}, 9'h1F3);
    end
    req = 2'b00; tick(); tick();

    // Reset while requester 1 owns the port and strobes are pending.
    cpu_tris_wr_en = 1; cpu_tris_in = 8'h12; cpu_port_wr_en = 1; cpu_port_in = 8'h34;
    tick(); clr();
    req = 2'b10; tick(); chk("grant 1", gnt, 2'b10);
    per_port_in = {8'h77, 8'h00}; per_port_wr_en = 2'b10; cpu_tris_wr_en = 1; rst_n = 0;
    tick(); clr();
    chk("midown gnt", gnt, 0);
    chk("midown wr_en", {tris_wr_en, port_wr_en}, 0);
    chk("midown shadows", {tris_in, port_in}, 16'hFF00);
    rst_n = 1; req = 2'b00; tick();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) req = req ^ 2'(1 << $urandom_range(0, N - 1));
      cpu_tris_wr_en = ($urandom_range(0, 4) == 0);
      cpu_port_wr_en = ($urandom_range(0, 4) == 0);
      cpu_tris_in = 8'($urandom); cpu_port_in = 8'($urandom);
      per_tris_wr_en = 2'($urandom); per_port_wr_en = 2'($urandom);
      per_tris_in = 16'($urandom); per_port_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) per_mask = 16'($urandom);
      tick();
    end
    rst_n = 1; clr(); tick(); tick();

    running = 0;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
